// File: rtl/arch_map_table.sv
// Architectural (committed) register map table.
// Retiring slots update the committed map oldest-first within a cycle, return
// the superseded physical tags to the free list, and a mispredicted retire
// triggers a one-cycle recovery pulse carrying the fully updated map.

`ifndef SYS_PHYS_REG
`define SYS_PHYS_REG 7
`endif

// One retire slot: resolves squash state, applies its write to the map view
// handed down from older slots and reports the tag it displaces.
module arch_map_lane #(
  parameter int PR_W = `SYS_PHYS_REG
) (
  input  logic                  valid,
  input  logic                  mispred,
  input  logic                  kill_in,
  input  logic [4:0]            arch,
  input  logic [PR_W-1:0]       new_tag,
  input  logic [31:0][PR_W-1:0] tbl_in,
  output logic [31:0][PR_W-1:0] tbl_out,
  output logic                  eff,
  output logic                  kill_out,
  output logic                  free_valid,
  output logic [PR_W-1:0]       free_tag
);
  logic wr;

  assign eff      = valid & ~kill_in;
  // A mispredict kills every younger slot; the branch itself still commits.
  assign kill_out = kill_in | (valid & mispred);
  // r0 is hardwired: counted as committed but never remapped or freed.
  assign wr       = eff & (arch != 5'd0);

  // Forward the map as seen by younger slots, with this slot's write applied.
  always_comb begin
    tbl_out    = tbl_in;
    free_valid = wr;
    free_tag   = '0;
    if (wr) begin
      tbl_out[arch] = new_tag;
      free_tag      = tbl_in[arch];
    end
  end
endmodule

module arch_map_table #(
  parameter int PR_W = `SYS_PHYS_REG,
  parameter int N_RT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_RT-1:0]            rt_valid,
  input  logic [N_RT-1:0][4:0]       rt_arch_reg,
  input  logic [N_RT-1:0][PR_W-1:0]  rt_new_tag,
  input  logic [N_RT-1:0]            rt_mispred,
  output logic [31:0][PR_W-1:0]      mt_checkpoint_tbl,
  output logic                       fch_rec_enable,
  output logic [N_RT-1:0]            fl_free_valid,
  output logic [N_RT-1:0][PR_W-1:0]  fl_free_tag,
  output logic [1:0]                 rt_commit_cnt
);
  typedef enum logic {NORMAL = 1'b0, RECOVER = 1'b1} state_t;

  state_t state, state_nxt;

  logic [31:0][PR_W-1:0] map_q;
  logic [N_RT:0][31:0][PR_W-1:0] tbl_chain;
  logic [N_RT:0]         kill_chain;
  logic [N_RT-1:0]       eff;
  logic [N_RT-1:0]       free_valid_c;
  logic [N_RT-1:0][PR_W-1:0] free_tag_c;
  logic [1:0]            cnt_c;
  logic                  mis_eff;

  // Oldest slot sees the committed map; in RECOVER every slot starts killed.
  assign tbl_chain[N_RT]  = map_q;
  assign kill_chain[N_RT] = (state != NORMAL);

  for (genvar g = 0; g < N_RT; g++) begin : g_lane
    arch_map_lane #(.PR_W(PR_W)) u_lane (
      .valid      (rt_valid[g]),
      .mispred    (rt_mispred[g]),
      .kill_in    (kill_chain[g+1]),
      .arch       (rt_arch_reg[g]),
      .new_tag    (rt_new_tag[g]),
      .tbl_in     (tbl_chain[g+1]),
      .tbl_out    (tbl_chain[g]),
      .eff        (eff[g]),
      .kill_out   (kill_chain[g]),
      .free_valid (free_valid_c[g]),
      .free_tag   (free_tag_c[g])
    );
  end

  // In NORMAL the chain only ends killed if some effective slot mispredicted.
  assign mis_eff = (state == NORMAL) & kill_chain[0];

  // Number of committing slots this cycle.
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < N_RT; i++) cnt_c = cnt_c + 2'(eff[i]);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= NORMAL;
    else     state <= state_nxt;
  end

  // FSM next state: recovery lasts exactly one cycle, mispredicts there are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (mis_eff) state_nxt = RECOVER;
      RECOVER: state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  // FSM outputs: recovery pulse straight from the state register.
  always_comb begin
    fch_rec_enable = (state == RECOVER);
  end

  // Committed map and free-list return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) map_q[i] <= PR_W'(i);
      fl_free_valid <= '0;
      fl_free_tag   <= '0;
      rt_commit_cnt <= '0;
    end else begin
      map_q         <= tbl_chain[0];
      fl_free_valid <= free_valid_c;
      fl_free_tag   <= free_tag_c;
      rt_commit_cnt <= cnt_c;
    end
  end

  assign mt_checkpoint_tbl = map_q;
endmodule

// File: tb/tb_arch_map_table.sv
// Scoreboard bench for arch_map_table: directed retire scenarios followed by
// random retirement traffic, checked against a per-register map model.
module tb_arch_map_table;
  localparam int PR_W = 7;
  localparam int N_RT = 3;

  logic clk = 1'b0;
  logic rst;
  logic [N_RT-1:0]            rt_valid;
  logic [N_RT-1:0][4:0]       rt_arch_reg;
  logic [N_RT-1:0][PR_W-1:0]  rt_new_tag;
  logic [N_RT-1:0]            rt_mispred;
  logic [31:0][PR_W-1:0]      mt_checkpoint_tbl;
  logic                       fch_rec_enable;
  logic [N_RT-1:0]            fl_free_valid;
  logic [N_RT-1:0][PR_W-1:0]  fl_free_tag;
  logic [1:0]                 rt_commit_cnt;

  arch_map_table #(.PR_W(PR_W), .N_RT(N_RT)) dut (
    .clk               (clk),
    .rst               (rst),
    .rt_valid          (rt_valid),
    .rt_arch_reg       (rt_arch_reg),
    .rt_new_tag        (rt_new_tag),
    .rt_mispred        (rt_mispred),
    .mt_checkpoint_tbl (mt_checkpoint_tbl),
    .fch_rec_enable    (fch_rec_enable),
    .fl_free_valid     (fl_free_valid),
    .fl_free_tag       (fl_free_tag),
    .rt_commit_cnt     (rt_commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0][PR_W-1:0]     tbl;
    logic                      rec;
    logic [N_RT-1:0]           fv;
    logic [N_RT-1:0][PR_W-1:0] ft;
    logic [1:0]                cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   stim_done = 1'b0;

  // Reference model: committed map as plain integers plus a recovery flag.
  int m_map[32];
  bit m_rec;

  task automatic model_step(input logic r, input logic [N_RT-1:0] v,
                            input logic [N_RT-1:0][4:0] a,
                            input logic [N_RT-1:0][PR_W-1:0] t,
                            input logic [N_RT-1:0] m);
    exp_t e;
    bit   stop;
    int   cnt;
    e.fv = '0; e.ft = '0; cnt = 0;
    if (r) begin
      for (int i = 0; i < 32; i++) m_map[i] = i;
      m_rec = 1'b0;
    end else if (m_rec) begin
      m_rec = 1'b0;
    end else begin
      stop = 1'b0;
      for (int i = N_RT-1; i >= 0; i--) begin
        if (!stop && v[i]) begin
          cnt++;
          if (a[i] != 0) begin
            e.fv[i] = 1'b1;
            e.ft[i] = PR_W'(m_map[a[i]]);
            m_map[a[i]] = int'(t[i]);
          end
          if (m[i]) begin
            stop  = 1'b1;
            m_rec = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < 32; i++) e.tbl[i] = PR_W'(m_map[i]);
    e.rec = m_rec;
    e.cnt = 2'(cnt);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs and record what the next edge must produce.
  task automatic drive(input logic r, input logic [N_RT-1:0] v,
                       input logic [N_RT-1:0][4:0] a,
                       input logic [N_RT-1:0][PR_W-1:0] t,
                       input logic [N_RT-1:0] m);
    @(negedge clk);
    rst = r; rt_valid = v; rt_arch_reg = a; rt_new_tag = t; rt_mispred = m;
    model_step(r, v, a, t, m);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every edge presents a full output set; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("table",     256'(mt_checkpoint_tbl), 256'(e.tbl));
        chk("rec",       256'(fch_rec_enable),    256'(e.rec));
        chk("free_vld",  256'(fl_free_valid),     256'(e.fv));
        chk("free_tag",  256'(fl_free_tag),       256'(e.ft));
        chk("commit",    256'(rt_commit_cnt),     256'(e.cnt));
        chk("r0_zero",   256'(mt_checkpoint_tbl[0]), 256'(0));
      end
    end
  end

  initial begin
    logic [N_RT-1:0]            v;
    logic [N_RT-1:0][4:0]       a;
    logic [N_RT-1:0][PR_W-1:0]  t;
    logic [N_RT-1:0]            m;
    int   wait_cyc;
    rst = 1'b1; rt_valid = '0; rt_arch_reg = '0; rt_new_tag = '0; rt_mispred = '0;
    for (int i = 0; i < 32; i++) m_map[i] = i;
    m_rec = 1'b0;

    drive(1'b1, 3'b000, '0, '0, 3'b000);
    drive(1'b1, 3'b000, '0, '0, 3'b000);
    // slot2 r5 -> 40
    a = {5'd5, 5'd0, 5'd0}; t = {7'd40, 7'd0, 7'd0};
    drive(1'b0, 3'b100, a, t, 3'b000);
    // same-register chain on r7
    a = {5'd7, 5'd7, 5'd7}; t = {7'd41, 7'd42, 7'd43};
    drive(1'b0, 3'b111, a, t, 3'b000);
    // slot1 mispredict on r0; slot0 squashed
    a = {5'd3, 5'd0, 5'd4}; t = {7'd50, 7'd0, 7'd51};
    drive(1'b0, 3'b111, a, t, 3'b010);
    // retire during RECOVER, with a mispredict that must be dropped
    a = {5'd0, 5'd0, 5'd6}; t = {7'd0, 7'd0, 7'd52};
    drive(1'b0, 3'b001, a, t, 3'b001);
    drive(1'b0, 3'b000, '0, '0, 3'b000);
    // slot0 retires r0
    a = {5'd0, 5'd0, 5'd0}; t = {7'd0, 7'd0, 7'd60};
    drive(1'b0, 3'b001, a, t, 3'b000);
    // mispredict, then reset during the RECOVER cycle
    a = {5'd9, 5'd10, 5'd11}; t = {7'd61, 7'd62, 7'd63};
    drive(1'b0, 3'b111, a, t, 3'b100);
    drive(1'b1, 3'b111, a, t, 3'b000);
    drive(1'b0, 3'b000, '0, '0, 3'b000);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N_RT; i++) begin
        v[i] = 1'($urandom_range(0, 3) != 0);
        a[i] = (n % 2 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        t[i] = PR_W'($urandom_range(0, 127));
        m[i] = 1'($urandom_range(0, 9) == 0);
      end
      drive(1'($urandom_range(0, 49) == 0), v, a, t, m);
    end
    drive(1'b0, 3'b000, '0, '0, 3'b000);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/arch_map_table.md
ARCH_MAP_TABLE -- requirements
Module: arch_map_table

Interface
REQ-001 Parameter PR_W, default `SYS_PHYS_REG, physical tag width.
REQ-002 Parameter N_RT, default 3, retire slots per cycle; slot N_RT-1 oldest, slot 0 youngest.
REQ-003 Reset rst, synchronous, active-high; clock clk.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rt_valid  in  [N_RT-1:0]  slot i retires an instruction this cycle.
REQ-007 rt_arch_reg  in  [N_RT-1:0][4:0]  destination architectural register of slot i.
REQ-008 rt_new_tag  in  [N_RT-1:0][PR_W-1:0]  physical tag assigned to slot i at dispatch.
REQ-009 rt_mispred  in  [N_RT-1:0]  slot i is a retiring mispredicted branch.
REQ-010 mt_checkpoint_tbl  out  [31:0][PR_W-1:0]  registered committed map, feeds speculative map table recovery.
REQ-011 fch_rec_enable  out  1  registered one-cycle recovery pulse.
REQ-012 fl_free_valid  out  [N_RT-1:0]  registered; slot i returns a tag to the free list.
REQ-013 fl_free_tag  out  [N_RT-1:0][PR_W-1:0]  registered freed (previous committed) tag of slot i.
REQ-014 rt_commit_cnt  out  [1:0]  registered number of slots actually committed last cycle.

Function
REQ-015 Slot i is effective iff rt_valid[i], FSM in NORMAL, and no older slot j>i has rt_valid[j] & rt_mispred[j].
- The mispredicted slot itself is effective; all younger slots are squashed regardless of rt_valid.
REQ-016 Effective slots are applied oldest to youngest (N_RT-1 down to 0) in one cycle; result registered into the table at the next edge.
REQ-017 Effective slot with rt_arch_reg != 0: table[rt_arch_reg] <= rt_new_tag; fl_free_valid[i] <= 1; fl_free_tag[i] <= mapping of rt_arch_reg as seen after all older slots in the same cycle.
- Same-cycle same-register chain: younger slot frees the older slot's rt_new_tag, not the pre-cycle entry; final entry is the youngest slot's tag.
REQ-018 Effective slot with rt_arch_reg == 0: no table update, fl_free_valid[i] <= 0; still counted in rt_commit_cnt.
REQ-019 Non-effective slot: fl_free_valid[i] <= 0, fl_free_tag[i] <= 0.
REQ-020 rt_commit_cnt <= count of effective slots (0..3).
REQ-021 FSM states NORMAL, RECOVER. NORMAL -> RECOVER when any effective slot has rt_mispred; RECOVER -> NORMAL unconditionally after one cycle.
REQ-022 fch_rec_enable is 1 exactly during RECOVER; mt_checkpoint_tbl in that cycle already includes every update from the mispredict cycle.
REQ-023 In RECOVER all rt_* inputs are ignored: no table change, fl_free_valid = 0, rt_commit_cnt = 0.
REQ-024 Back-to-back mispredicts impossible: mispredict arriving in RECOVER is dropped with no pulse extension.
REQ-025 mt_checkpoint_tbl[0] stays 0 at all times.
REQ-026 Table changes only via REQ-017 or reset; no combinational path from rt_* to any output.

Reset
REQ-027 On rst: table[i] <= i (identity, i=0..31), FSM <= NORMAL, fch_rec_enable <= 0, fl_free_valid <= 0, fl_free_tag <= 0, rt_commit_cnt <= 0.
REQ-028 rst has priority over retirement and RECOVER; rst asserted during RECOVER ends the pulse on the next edge.

Verification
REQ-029 After reset, slot2 retires r5->tag 40 -> next cycle table[5]=40, fl_free_valid=3'b100, fl_free_tag[2]=5, rt_commit_cnt=1.
REQ-030 Same cycle slot2 r7->41, slot1 r7->42, slot0 r7->43 -> table[7]=43; freed tags 7,41,42 on slots 2,1,0.
REQ-031 Slot1 mispred (arch r0), slots 2 and 0 valid writing r3->50 and r4->51 -> table[3]=50, table[4]=4, fch_rec_enable=1 for exactly one cycle, rt_commit_cnt=2.
REQ-032 Retire valid slot during RECOVER (r6->52) -> table[6] stays 6, fl_free_valid=0, rt_commit_cnt=0.
REQ-033 Slot0 retires r0->60 -> table[0]=0, fl_free_valid=0, rt_commit_cnt=1.
REQ-034 rst asserted cycle after a mispredict retire -> next cycle fch_rec_enable=0, table identity, FSM NORMAL.
